in_port_ctrl: RTL and testbench
===============================

Name: in_port_ctrl

Overview:
Input-port front end that sits directly upstream of the processor's `In_port`/`int` pins.
- Accepts bytes from an external source over a valid/ready handshake and buffers them in a small FIFO.
- Presents the head byte on `In_port` and raises an interrupt pulse for each byte.
- Pops the byte only when the CPU acknowledges, after its ISR has executed IN.
- Keeps the processor's single-register input port from losing back-to-back data.

Parameters:
DATA_W, 8, byte width; must match the CPU port width.
DEPTH, 4, FIFO entries; power of 2, ≥2.
INT_HOLD, 2, cycles `int` is held high per byte; ≥1.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
src_data  in  DATA_W  byte from external source
src_valid  in  1  src_data valid
src_ready  out  1  block can accept a byte
cpu_rd_ack  in  1  1-cycle pulse: CPU has consumed In_port
irq_mask  in  1  1 = do not start new interrupts
In_port  out  DATA_W  byte presented to the CPU (registered)
int  out  1  interrupt request to the CPU (registered)
count  out  $clog2(DEPTH)+1  current FIFO occupancy
busy  out  1  high in RAISE or WAIT_ACK

Behaviour:
- Clock and reset: one clock (`clk`). `rst` is asynchronous, active-low; it is fixed as decided.
- Reset values (all outputs):
  - state = IDLE
  - `In_port` = 0, `int` = 0, `count` = 0, `busy` = 0
  - read and write pointers = 0
  - `src_ready` = 1 (because the FIFO is not full)
- Reset asserted mid-operation: all contents are discarded immediately, with no pending interrupt.
- Push: when `src_valid` && `src_ready` at a rising edge, write `src_data` at `wr_ptr` and increment `wr_ptr` modulo DEPTH.
- `src_ready` = !full. It is combinational from `count` and does not look ahead at a same-cycle pop.
- Pop: only when state == WAIT_ACK && `cpu_rd_ack` at a rising edge. Increment `rd_ptr` modulo DEPTH.
- Push and pop in the same edge: both occur and `count` is unchanged.
- `count` range is 0..DEPTH. Pointers use DATA-independent wrap.
- State machine:
  - IDLE → RAISE when `count` != 0 && !`irq_mask`.
    - On that edge, `In_port` <= fifo[rd_ptr], `int` <= 1, and the hold counter <= INT_HOLD-1.
  - RAISE: `int` stays 1.
    - Hold counter == 0 → WAIT_ACK, with `int` <= 0.
    - Otherwise decrement the hold counter.
  - WAIT_ACK: `int` = 0 and `In_port` is held stable.
    - `cpu_rd_ack` → pop, then go to IDLE.
- A byte pushed into an empty FIFO at edge N (unmasked, IDLE):
  - `In_port` is valid and `int` = 1 from edge N+1.
  - `int` falls at edge N+1+INT_HOLD.
- After a pop with `count` still ≥1, the next RAISE starts no earlier than one cycle after returning to IDLE. That gap is the minimum inter-interrupt spacing the CPU edge detector needs.
- `cpu_rd_ack` in IDLE or RAISE is ignored: no pop and no error.
- `irq_mask` is sampled only in IDLE. Masking during RAISE or WAIT_ACK does not abort the transaction.
- A pushed byte is never dropped. A full FIFO back-pressures the source through `src_ready`.
- `busy` = (state != IDLE).

Decomposition:
- Shared package `in_port_ctrl_pkg`:
  - state enum {IDLE, RAISE, WAIT_ACK} (2-bit encoding)
  - default parameter constants
- One sub-module: `sync_fifo`, parameterised on DATA_W and DEPTH.
  - Ports: push, pop, wdata, rdata (combinational head), full, empty, count.
- `in_port_ctrl` contains the FSM, the hold counter, and the output registers.

Test Plan:
- Reset release, idle: `src_ready`=1, `int`=0, `In_port`=0x00, `count`=0, held for 10 cycles with no source traffic.
- Single byte 0xA5, INT_HOLD=2:
  - `In_port`=0xA5 and `int`=1 on edges N+1 and N+2; `int`=0 at N+3.
  - `cpu_rd_ack` at N+5 → `count`=0 and state IDLE at N+6.
- Burst of 0x11,0x22,0x33,0x44,0x55 with no acks:
  - `src_ready` falls after the 4th push; `count`=4; 0x55 is held by the source.
  - Each ack yields `In_port` sequence 0x11..0x55 in order; 0x55 is accepted after the first pop.
- Mask: `irq_mask`=1, push 0x7E → no `int` for 20 cycles and `count`=1. Clear the mask → `int` rises the next edge with `In_port`=0x7E.
- Stray ack: `cpu_rd_ack` pulsed during RAISE → `count` unchanged and `In_port` unchanged. A later ack in WAIT_ACK pops normally.
- Reset mid-operation: assert `rst` low during WAIT_ACK with `count`=3 → `int`=0, `In_port`=0, `count`=0 immediately (asynchronously). After release, no interrupt fires.

Source files
------------

// File: rtl/in_port_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : in_port_ctrl_pkg
// Description : Shared types and default constants for the CPU input-port
//               front end (controller state encoding, parameter defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package in_port_ctrl_pkg;

  // Controller state; 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAISE    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam int c_data_w_default   = 8;  // must match the CPU port width
  localparam int c_depth_default    = 4;  // power of 2, >= 2
  localparam int c_int_hold_default = 2;  // cycles int is held high, >= 1

endpackage : in_port_ctrl_pkg
`default_nettype wire

// File: rtl/in_port_ctrl_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with a combinational head output.
//               Pointers wrap naturally at DEPTH (power of 2); occupancy is
//               tracked in a separate counter covering 0..DEPTH.
// Ports       : clk, rst (async, active-low)
//               push / wdata  - write one entry (ignored when full)
//               pop           - retire the head entry (ignored when empty)
//               rdata         - current head entry (combinational)
//               full, empty   - occupancy flags
//               count         - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
  import in_port_ctrl_pkg::*;
#(
  parameter int DATA_W = c_data_w_default,
  parameter int DEPTH  = c_depth_default
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_ptr_w = $clog2(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_push;
  logic               w_pop;

  // Guard against overflow/underflow regardless of what the caller does.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign full  = (r_count == (c_ptr_w+1)'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rd_ptr];

  // Storage needs no reset: only pointer/count state defines validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/in_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : in_port_ctrl
// Description : CPU input-port front end. Buffers source bytes in a FIFO,
//               presents the head byte on In_port, pulses the interrupt
//               request for INT_HOLD cycles per byte and retires the byte when
//               the CPU acknowledges it after its ISR has read the port.
// Ports       : clk, rst (async, active-low)
//               src_data/src_valid/src_ready - byte source handshake
//               cpu_rd_ack - 1-cycle pulse, CPU has consumed In_port
//               irq_mask   - blocks new interrupts (sampled only when idle)
//               In_port    - registered byte presented to the CPU
//               int_req    - registered interrupt request (the CPU int pin)
//               count      - FIFO occupancy
//               busy       - a byte is being offered to the CPU
// Revision    : 1.0 - initial release
// ============================================================================
module in_port_ctrl
  import in_port_ctrl_pkg::*;
#(
  parameter int DATA_W   = c_data_w_default,
  parameter int DEPTH    = c_depth_default,
  parameter int INT_HOLD = c_int_hold_default
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      src_data,
  input  logic                   src_valid,
  output logic                   src_ready,
  input  logic                   cpu_rd_ack,
  input  logic                   irq_mask,
  output logic [DATA_W-1:0]      In_port,
  output logic                   int_req,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy
);

  // Wide enough to hold INT_HOLD-1 even when INT_HOLD == 1.
  localparam int c_hold_w = $clog2(INT_HOLD + 1);

  state_t              r_state;
  logic [c_hold_w-1:0] r_hold;
  logic                w_full;
  logic                w_empty;
  logic [DATA_W-1:0]   w_head;
  logic                w_push;
  logic                w_pop;

  // Ready reflects the current occupancy only; a same-cycle pop does not
  // open the FIFO early.
  assign src_ready = !w_full;
  assign w_push    = src_valid && !w_full;
  // Acks outside WAIT_ACK are stray and must not retire anything.
  assign w_pop     = (r_state == WAIT_ACK) && cpu_rd_ack;
  assign busy      = (r_state != IDLE);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (src_data),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_hold  <= '0;
      In_port <= '0;
      int_req <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // The mask only gates the start of a transaction.
          if (!w_empty && !irq_mask) begin
            r_state <= RAISE;
            In_port <= w_head;
            int_req <= 1'b1;
            r_hold  <= c_hold_w'(INT_HOLD - 1);
          end
        end
        RAISE: begin
          if (r_hold == '0) begin
            r_state <= WAIT_ACK;
            int_req <= 1'b0;
          end else begin
            r_hold <= r_hold - 1'b1;
          end
        end
        WAIT_ACK: begin
          // Returning through IDLE enforces a one-cycle gap before the next
          // interrupt so the CPU sees a clean rising edge.
          if (cpu_rd_ack) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          int_req <= 1'b0;
        end
      endcase
    end
  end

endmodule : in_port_ctrl
`default_nettype wire

// File: tb/tb_in_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_in_port_ctrl
// Description : Self-checking bench for in_port_ctrl. Directed scenarios plus
//               a randomized run against a transaction-level model: a byte
//               queue and the number of edges since the current interrupt
//               started.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_in_port_ctrl;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4;
  localparam int INT_HOLD = 2;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] src_data = '0;
  logic              src_valid = 1'b0;
  logic              cpu_rd_ack = 1'b0;
  logic              irq_mask = 1'b0;
  logic              src_ready;
  logic [DATA_W-1:0] In_port;
  logic              int_req;
  logic [CNT_W-1:0]  count;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // Model: bytes held by the block, edges since the interrupt began
  // (-1 = nothing offered to the CPU), and the byte last presented.
  logic [DATA_W-1:0] q[$];
  int                t = -1;
  logic [DATA_W-1:0] exp_in = '0;

  in_port_ctrl #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .INT_HOLD (INT_HOLD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .cpu_rd_ack (cpu_rd_ack),
    .irq_mask   (irq_mask),
    .In_port    (In_port),
    .int_req    (int_req),
    .count      (count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    q.delete();
    t      = -1;
    exp_in = '0;
  endtask

  // Advance one clock edge and update the model from the inputs seen there.
  task automatic tick();
    int                sz;
    bit                do_push, do_pop, do_start;
    logic [DATA_W-1:0] head, din;
    sz       = q.size();
    din      = src_data;
    head     = (sz > 0) ? q[0] : '0;
    do_push  = src_valid && (sz < DEPTH);
    do_pop   = cpu_rd_ack && (t > INT_HOLD);   // int already low: waiting on ack
    do_start = (t < 0) && (sz > 0) && !irq_mask;
    @(posedge clk);
    #1;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back(din);
    if (do_pop) t = -1;
    else if (do_start) begin
      t      = 1;
      exp_in = head;
    end else if (t > 0) t = t + 1;
  endtask

  task automatic drain();
    int g = 0;
    src_valid = 1'b0;
    irq_mask  = 1'b0;
    while ((q.size() > 0 || t > 0) && g < 200) begin
      cpu_rd_ack = (t > INT_HOLD);
      tick();
      g++;
    end
    cpu_rd_ack = 1'b0;
    checks++;
    if (count !== '0 || busy !== 1'b0 || g >= 200) begin
      errors++;
      $display("FAIL drain: count=%0d busy=%0b cycles=%0d, required count=0 busy=0 within 200", count, busy, g);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (src_ready !== 1'b1 || int_req !== 1'b0 || In_port !== 8'h00 || count !== '0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: ready=%0b int=%0b In_port=%02h count=%0d busy=%0b, required 1 0 00 0 0",
                 i, src_ready, int_req, In_port, count, busy);
      end
    end
  endtask

  task automatic test_single();
    src_data = 8'hA5; src_valid = 1'b1;
    tick();                                   // edge N
    src_valid = 1'b0;
    tick();                                   // N+1
    checks++;
    if (In_port !== 8'hA5 || int_req !== 1'b1) begin
      errors++;
      $display("FAIL single_n1: In_port=%02h int=%0b, required a5 1", In_port, int_req);
    end
    tick();                                   // N+2
    checks++;
    if (int_req !== 1'b1) begin
      errors++;
      $display("FAIL single_n2: int=%0b, required 1", int_req);
    end
    tick();                                   // N+3
    checks++;
    if (int_req !== 1'b0 || busy !== 1'b1 || In_port !== 8'hA5) begin
      errors++;
      $display("FAIL single_n3: int=%0b busy=%0b In_port=%02h, required 0 1 a5", int_req, busy, In_port);
    end
    tick();                                   // N+4
    cpu_rd_ack = 1'b1;
    tick();                                   // N+5
    cpu_rd_ack = 1'b0;
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL single_pop: count=%0d, required 0", count);
    end
    tick();                                   // N+6
    checks++;
    if (busy !== 1'b0 || count !== '0 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%0b count=%0d int=%0b, required 0 0 0", busy, count, int_req);
    end
  endtask

  task automatic test_burst();
    logic [DATA_W-1:0] b [5];
    int g;
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44; b[4] = 8'h55;
    irq_mask = 1'b1;                          // hold interrupts until the FIFO is full
    for (int i = 0; i < 4; i++) begin
      src_data = b[i]; src_valid = 1'b1;
      tick();
    end
    src_data = b[4];                          // source keeps offering 0x55
    checks++;
    if (count !== 3'd4 || src_ready !== 1'b0) begin
      errors++;
      $display("FAIL burst_full: count=%0d ready=%0b, required 4 0", count, src_ready);
    end
    irq_mask = 1'b0;
    for (int k = 0; k < 5; k++) begin
      g = 0;
      while (int_req !== 1'b1 && g < 20) begin tick(); g++; end
      checks++;
      if (int_req !== 1'b1 || In_port !== b[k]) begin
        errors++;
        $display("FAIL burst_order[%0d]: int=%0b In_port=%02h, required 1 %02h", k, int_req, In_port, b[k]);
      end
      g = 0;
      while (int_req !== 1'b0 && g < 20) begin tick(); g++; end
      cpu_rd_ack = 1'b1;
      tick();
      cpu_rd_ack = 1'b0;
      if (k == 0) begin
        checks++;
        if (count !== 3'd3) begin
          errors++;
          $display("FAIL burst_pop_no_lookahead: count=%0d, required 3", count);
        end
        tick();                               // 0x55 accepted now
        src_valid = 1'b0;
        checks++;
        if (count !== 3'd4) begin
          errors++;
          $display("FAIL burst_accept_55: count=%0d, required 4", count);
        end
      end
    end
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL burst_empty: count=%0d, required 0", count);
    end
  endtask

  task automatic test_mask();
    irq_mask = 1'b1;
    src_data = 8'h7E; src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (int_req !== 1'b0) begin
        errors++;
        $display("FAIL mask_hold[%0d]: int=%0b, required 0", i, int_req);
      end
    end
    checks++;
    if (count !== 3'd1) begin
      errors++;
      $display("FAIL mask_count: count=%0d, required 1", count);
    end
    irq_mask = 1'b0;
    tick();
    checks++;
    if (int_req !== 1'b1 || In_port !== 8'h7E) begin
      errors++;
      $display("FAIL mask_release: int=%0b In_port=%02h, required 1 7e", int_req, In_port);
    end
    drain();
  endtask

  task automatic test_stray_ack();
    int g = 0;
    cpu_rd_ack = 1'b1;                        // ack while idle and empty
    tick();
    cpu_rd_ack = 1'b0;
    checks++;
    if (count !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stray_idle: count=%0d busy=%0b, required 0 0", count, busy);
    end
    src_data = 8'h3C; src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
    tick();                                   // now raising
    cpu_rd_ack = 1'b1;
    tick();
    cpu_rd_ack = 1'b0;
    checks++;
    if (count !== 3'd1 || In_port !== 8'h3C || int_req !== 1'b1) begin
      errors++;
      $display("FAIL stray_raise: count=%0d In_port=%02h int=%0b, required 1 3c 1", count, In_port, int_req);
    end
    while (int_req !== 1'b0 && g < 20) begin tick(); g++; end
    cpu_rd_ack = 1'b1;
    tick();
    cpu_rd_ack = 1'b0;
    checks++;
    if (count !== '0) begin
      errors++;
      $display("FAIL stray_then_pop: count=%0d, required 0", count);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    src_valid = 1'b1;
    src_data = 8'hA1; tick();
    src_data = 8'hA2; tick();
    src_data = 8'hA3; tick();
    src_valid = 1'b0;
    tick();                                   // interrupt for 0xA1 has fallen
    checks++;
    if (count !== 3'd3 || busy !== 1'b1 || int_req !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_setup: count=%0d busy=%0b int=%0b, required 3 1 0", count, busy, int_req);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (int_req !== 1'b0 || In_port !== 8'h00 || count !== '0 || busy !== 1'b0 || src_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_async: int=%0b In_port=%02h count=%0d busy=%0b ready=%0b, required 0 00 0 0 1",
               int_req, In_port, count, busy, src_ready);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (int_req !== 1'b0 || count !== '0) begin
        errors++;
        $display("FAIL rstmid_quiet[%0d]: int=%0b count=%0d, required 0 0", i, int_req, count);
      end
    end
  endtask

  task automatic test_random();
    logic exp_int;
    for (int i = 0; i < 600; i++) begin
      src_valid  = ($urandom_range(0, 2) == 0);
      src_data   = 8'($urandom);
      irq_mask   = ($urandom_range(0, 9) == 0);
      cpu_rd_ack = ($urandom_range(0, 3) == 0);
      tick();
      exp_int = (t >= 1 && t <= INT_HOLD);
      checks++;
      if (int_req !== exp_int || In_port !== exp_in || count !== CNT_W'(q.size()) ||
          src_ready !== (q.size() < DEPTH) || busy !== (t > 0)) begin
        errors++;
        $display("FAIL random[%0d]: int=%0b In_port=%02h count=%0d ready=%0b busy=%0b, required %0b %02h %0d %0b %0b",
                 i, int_req, In_port, count, src_ready, busy,
                 exp_int, exp_in, q.size(), (q.size() < DEPTH), (t > 0));
      end
    end
    cpu_rd_ack = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_mask();
    test_stray_ack();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_in_port_ctrl
`default_nettype wire
